ir_transmit: RTL and testbench
==============================

// Module: ir_transmit
// PURPOSE
//  NEC-format infrared transmitter; the counterpart of the IR receive path. Serialises a 32-bit
//  frame (LSB first, so the receiver's 32-bit data word equals iDATA) or a repeat code onto the
//  IrDA TX pin. The pin carries a 38 kHz-modulated carrier during marks and is low during spaces.
//  Driven by the IC-tester control logic to loop back / emulate remote key presses.
// PARAMETERS
//  UNIT_CYCLES   28125  clocks per NEC unit (562.5 us at 50 MHz)
//  CARRIER_HALF  658    clocks per carrier half-period (~38 kHz at 50 MHz)
//  USE_CARRIER   1      1: oIRDA_TXD = carrier AND envelope; 0: oIRDA_TXD = envelope
//  GUARD_UNITS   72     idle units enforced after every frame (~40.5 ms)
// PORTS
//  iCLK       in   1   system clock (50 MHz PLL output)
//  iRST       in   1   asynchronous reset, active-high
//  iSTART     in   1   1-cycle request: send data frame from iDATA
//  iREPEAT    in   1   1-cycle request: send NEC repeat code
//  iDATA      in   32  frame; [7:0] custom, [15:8] custom/~custom, [23:16] key, [31:24] ~key
//  oBUSY      out  1   high from accepted request until end of guard
//  oDONE      out  1   1-cycle pulse when guard completes
//  oENV       out  1   unmodulated envelope (1 = mark)
//  oIRDA_TXD  out  1   LED drive
// BEHAVIOUR
//  One clock domain; iRST asynchronous, active-high. All outputs registered. Reset: every output 0,
//  state IDLE, counters 0, shift register 0. Asserting iRST mid-frame drops oENV/oIRDA_TXD at once.
//  Request accepted only when oBUSY=0. iSTART and iREPEAT in the same cycle: iSTART wins. Requests
//  while busy are ignored (not queued). iDATA is latched on the accept cycle; later changes ignored.
//  Latency: accept in cycle t -> oBUSY=1, oENV=1 from cycle t+1.
//  States and durations (units x UNIT_CYCLES clocks, exact):
//   IDLE       -> LEAD_MARK on accept
//   LEAD_MARK  16, env=1 -> LEAD_SPACE
//   LEAD_SPACE 8 (data) or 4 (repeat), env=0 -> BIT_MARK (data) / STOP_MARK (repeat)
//   BIT_MARK   1, env=1 -> BIT_SPACE
//   BIT_SPACE  1 if current bit 0, 3 if 1, env=0; shift right, bit count +1;
//              after 32nd bit -> STOP_MARK, else -> BIT_MARK
//   STOP_MARK  1, env=1 -> GUARD
//   GUARD      GUARD_UNITS, env=0; on last clock -> IDLE, oDONE=1 for that one cycle, oBUSY=0 next
//  Frame length (excl. guard): data = 89 + 2*popcount(iDATA) units; repeat = 21 units.
//  Counters: unit-clock counter wraps at UNIT_CYCLES-1; unit counter sized for max(16,GUARD_UNITS);
//  bit counter 6 bits, 0..32, no wrap.
//  Carrier: phase counter restarts at the first clock of every mark, so each mark starts with
//  carrier high; toggles every CARRIER_HALF clocks; held 0 during spaces.
//  oIRDA_TXD = env & carrier when USE_CARRIER=1, else env. Never high outside a mark.
// TESTING  (UNIT_CYCLES=10, CARRIER_HALF=2, GUARD_UNITS=4)
//  Reset: iRST=1 mid-LEAD_MARK -> all outputs 0 same cycle; after release, oBUSY=0, state IDLE.
//  iSTART, iDATA=0x00000000 -> lead 160/80 clocks, 32x(10 mark,10 space), stop 10; oBUSY high
//    890+40 clocks, single oDONE on last guard clock.
//  iSTART, iDATA=0xFFFFFFFF -> each space 30 clocks; frame 1530 clocks; oDONE at 1570.
//  iDATA=0xE31CFF00 through ir_transmit->IR_RECEIVE loopback at defaults -> receiver data
//    0xE31CFF00, data_ready pulses once.
//  iREPEAT -> 160 mark, 40 space, 10 mark, 40 guard; iSTART+iREPEAT same cycle -> data frame.
//  iSTART pulsed again while busy -> ignored, frame bit pattern unchanged; carrier: each mark
//    begins high, period 4 clocks, oIRDA_TXD=0 throughout every space.

Source files
------------

// File: rtl/ir_transmit.sv
// NEC infrared transmitter: serialises a 32-bit frame (LSB first) or a repeat code as a 38 kHz-modulated mark/space train.
// Accept in cycle t gives oBUSY/oENV high from t+1; requests are taken only while idle, and those arriving while busy are dropped.
module ir_transmit #(
    parameter int UNIT_CYCLES  = 28125,
    parameter int CARRIER_HALF = 658,
    parameter int USE_CARRIER  = 1,
    parameter int GUARD_UNITS  = 72
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iSTART,
    input  logic        iREPEAT,
    input  logic [31:0] iDATA,
    output logic        oBUSY,
    output logic        oDONE,
    output logic        oENV,
    output logic        oIRDA_TXD
);

    localparam int MAX_UNITS = (GUARD_UNITS > 16) ? GUARD_UNITS : 16;
    localparam int CW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam int UW = $clog2(MAX_UNITS);
    localparam int PW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
    localparam logic [CW-1:0] CLK_LAST   = CW'(UNIT_CYCLES - 1);
    localparam logic [PW-1:0] PH_LAST    = PW'(CARRIER_HALF - 1);
    localparam logic [UW-1:0] GUARD_LAST = UW'(GUARD_UNITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD_MARK,
        S_LEAD_SPACE,
        S_BIT_MARK,
        S_BIT_SPACE,
        S_STOP_MARK,
        S_GUARD
    } state_t;

    state_t         r_state;
    logic [CW-1:0]  r_clk_cnt;
    logic [UW-1:0]  r_unit_cnt;
    logic [31:0]    r_shift;
    logic [5:0]     r_bit_cnt;
    logic           r_rep;
    logic [PW-1:0]  r_ph;
    logic           r_car;
    logic           r_env;
    logic           r_txd;
    logic           r_busy;
    logic           r_done;

    state_t         w_state_nxt;
    logic [CW-1:0]  w_clk_nxt;
    logic [UW-1:0]  w_unit_nxt;
    logic [31:0]    w_shift_nxt;
    logic [5:0]     w_bit_nxt;
    logic           w_rep_nxt;
    logic [UW-1:0]  w_dur_last;
    logic           w_unit_end;
    logic           w_state_end;
    logic           w_env_nxt;
    logic           w_car_nxt;
    logic [PW-1:0]  w_ph_nxt;
    logic           w_txd_nxt;
    logic           w_done_nxt;

    // Last unit index of the current state; a data bit's space length comes from the LSB of the shifter.
    always_comb begin
        w_dur_last = '0;
        case (r_state)
            S_LEAD_MARK:  w_dur_last = UW'(15);
            S_LEAD_SPACE: w_dur_last = r_rep ? UW'(3) : UW'(7);
            S_BIT_SPACE:  w_dur_last = r_shift[0] ? UW'(2) : UW'(0);
            S_GUARD:      w_dur_last = GUARD_LAST;
            default:      w_dur_last = '0;
        endcase
    end

    assign w_unit_end  = (r_clk_cnt == CLK_LAST);
    assign w_state_end = w_unit_end && (r_unit_cnt == w_dur_last);

    always_comb begin
        w_state_nxt = r_state;
        w_clk_nxt   = r_clk_cnt;
        w_unit_nxt  = r_unit_cnt;
        w_shift_nxt = r_shift;
        w_bit_nxt   = r_bit_cnt;
        w_rep_nxt   = r_rep;
        if (r_state == S_IDLE) begin
            w_clk_nxt  = '0;
            w_unit_nxt = '0;
            if (iSTART) begin
                w_state_nxt = S_LEAD_MARK;
                w_shift_nxt = iDATA;
                w_bit_nxt   = '0;
                w_rep_nxt   = 1'b0;
            end else if (iREPEAT) begin
                w_state_nxt = S_LEAD_MARK;
                w_bit_nxt   = '0;
                w_rep_nxt   = 1'b1;
            end
        end else if (w_state_end) begin
            w_clk_nxt  = '0;
            w_unit_nxt = '0;
            case (r_state)
                S_LEAD_MARK:  w_state_nxt = S_LEAD_SPACE;
                S_LEAD_SPACE: w_state_nxt = r_rep ? S_STOP_MARK : S_BIT_MARK;
                S_BIT_MARK:   w_state_nxt = S_BIT_SPACE;
                S_BIT_SPACE: begin
                    w_shift_nxt = {1'b0, r_shift[31:1]};
                    w_bit_nxt   = r_bit_cnt + 6'd1;
                    w_state_nxt = (r_bit_cnt == 6'd31) ? S_STOP_MARK : S_BIT_MARK;
                end
                S_STOP_MARK:  w_state_nxt = S_GUARD;
                default:      w_state_nxt = S_IDLE;
            endcase
        end else if (w_unit_end) begin
            w_clk_nxt  = '0;
            w_unit_nxt = r_unit_cnt + UW'(1);
        end else begin
            w_clk_nxt = r_clk_cnt + CW'(1);
        end
    end

    assign w_env_nxt = (w_state_nxt == S_LEAD_MARK) || (w_state_nxt == S_BIT_MARK) ||
                       (w_state_nxt == S_STOP_MARK);

    // Marks are never adjacent, so a mark following a non-mark cycle is always a fresh mark.
    always_comb begin
        w_car_nxt = r_car;
        w_ph_nxt  = r_ph;
        if (!w_env_nxt) begin
            w_car_nxt = 1'b0;
            w_ph_nxt  = '0;
        end else if (!r_env) begin
            w_car_nxt = 1'b1;
            w_ph_nxt  = '0;
        end else if (r_ph == PH_LAST) begin
            w_car_nxt = ~r_car;
            w_ph_nxt  = '0;
        end else begin
            w_ph_nxt = r_ph + PW'(1);
        end
    end

    assign w_txd_nxt  = (USE_CARRIER != 0) ? (w_env_nxt & w_car_nxt) : w_env_nxt;
    assign w_done_nxt = (w_state_nxt == S_GUARD) && (w_clk_nxt == CLK_LAST) &&
                        (w_unit_nxt == GUARD_LAST);

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state    <= S_IDLE;
            r_clk_cnt  <= '0;
            r_unit_cnt <= '0;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_rep      <= 1'b0;
            r_ph       <= '0;
            r_car      <= 1'b0;
            r_env      <= 1'b0;
            r_txd      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_clk_cnt  <= w_clk_nxt;
            r_unit_cnt <= w_unit_nxt;
            r_shift    <= w_shift_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_rep      <= w_rep_nxt;
            r_ph       <= w_ph_nxt;
            r_car      <= w_car_nxt;
            r_env      <= w_env_nxt;
            r_txd      <= w_txd_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
            r_done     <= w_done_nxt;
        end
    end

    assign oBUSY     = r_busy;
    assign oDONE     = r_done;
    assign oENV      = r_env;
    assign oIRDA_TXD = r_txd;

endmodule

// File: tb/tb_ir_transmit.sv
// Scoreboard bench for ir_transmit: expected mark/space runs and frame summaries are queued at request time
// and compared against the observed envelope, carrier, busy window, done pulse and decoded data word.
module tb_ir_transmit;

    localparam int U    = 10;
    localparam int HALF = 2;
    localparam int G    = 4;

    typedef struct {
        bit lvl;
        int len;
    } seg_t;

    typedef struct {
        bit          rep;
        logic [31:0] data;
        int          len;
    } frm_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        repeat_i = 1'b0;
    logic [31:0] data_i = '0;
    logic        busy_o, done_o, env_o, txd_o;

    int n_tests = 0;
    int n_fail  = 0;

    seg_t exp_q[$];
    frm_t frm_q[$];

    ir_transmit #(
        .UNIT_CYCLES (U),
        .CARRIER_HALF(HALF),
        .USE_CARRIER (1),
        .GUARD_UNITS (G)
    ) dut (
        .iCLK     (clk),
        .iRST     (rst),
        .iSTART   (start_i),
        .iREPEAT  (repeat_i),
        .iDATA    (data_i),
        .oBUSY    (busy_o),
        .oDONE    (done_o),
        .oENV     (env_o),
        .oIRDA_TXD(txd_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor state: one run is a maximal stretch of constant envelope inside a busy window.
    bit          prev_busy = 1'b0;
    bit          cur_lvl   = 1'b0;
    int          run_len   = 0;
    int          seg_idx   = 0;
    int          busy_len  = 0;
    int          done_cnt  = 0;
    int          done_at   = 0;
    int          car_err   = 0;
    logic [31:0] word      = '0;

    task automatic end_run();
        seg_t e;
        if (exp_q.size() == 0) begin
            chk("seg_extra", 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            chk("seg_lvl", 64'(cur_lvl), 64'(e.lvl));
            chk("seg_len", 64'(run_len), 64'(e.len));
        end
        chk("carrier", 64'(car_err), 64'd0);
        if (!cur_lvl && seg_idx >= 3 && seg_idx <= 65 && seg_idx[0])
            word[(seg_idx - 3) / 2] = (run_len > 2 * U);
        seg_idx++;
        car_err = 0;
    endtask

    task automatic end_frame();
        frm_t f;
        if (frm_q.size() == 0) begin
            chk("frame_extra", 64'd1, 64'd0);
        end else begin
            f = frm_q.pop_front();
            chk("busy_len", 64'(busy_len), 64'(f.len));
            chk("done_cnt", 64'(done_cnt), 64'd1);
            chk("done_at", 64'(done_at), 64'(f.len));
            if (!f.rep) chk("rx_word", 64'(word), 64'(f.data));
            chk("seg_left", 64'(exp_q.size()), 64'd0);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_busy = 1'b0;
            run_len   = 0;
            car_err   = 0;
        end else begin
            if (busy_o) begin
                if (!prev_busy) begin
                    busy_len = 0;
                    seg_idx  = 0;
                    run_len  = 0;
                    done_cnt = 0;
                    done_at  = 0;
                    car_err  = 0;
                    word     = '0;
                    cur_lvl  = env_o;
                end else if (env_o != cur_lvl) begin
                    end_run();
                    cur_lvl = env_o;
                    run_len = 0;
                end
                busy_len++;
                run_len++;
                if (txd_o != (cur_lvl ? (((run_len - 1) / HALF) % 2 == 0) : 1'b0)) car_err++;
                if (done_o) begin
                    done_cnt++;
                    done_at = busy_len;
                end
            end else begin
                if (done_o) chk("done_idle", 64'd1, 64'd0);
                if (env_o || txd_o) chk("idle_out", {62'd0, env_o, txd_o}, 64'd0);
                if (prev_busy) begin
                    end_run();
                    end_frame();
                end
            end
            prev_busy = busy_o;
        end
    end

    task automatic push_frame(input bit rep, input logic [31:0] d);
        int tot;
        exp_q.push_back('{1'b1, 16 * U});
        tot = 16 * U;
        if (rep) begin
            exp_q.push_back('{1'b0, 4 * U});
            tot += 4 * U;
        end else begin
            exp_q.push_back('{1'b0, 8 * U});
            tot += 8 * U;
            for (int i = 0; i < 32; i++) begin
                exp_q.push_back('{1'b1, U});
                exp_q.push_back('{1'b0, d[i] ? 3 * U : U});
                tot += d[i] ? 4 * U : 2 * U;
            end
        end
        exp_q.push_back('{1'b1, U});
        exp_q.push_back('{1'b0, G * U});
        tot += U + G * U;
        frm_q.push_back('{rep, d, tot});
    endtask

    task automatic send(input logic s, input logic r, input logic [31:0] d);
        push_frame(!s, d);
        @(posedge clk);
        #1;
        start_i  = s;
        repeat_i = r;
        data_i   = d;
        @(posedge clk);
        #1;
        start_i  = 1'b0;
        repeat_i = 1'b0;
        data_i   = $urandom;
        chk("acc_out", {61'd0, busy_o, env_o, txd_o}, 64'd7);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_o && n < 5000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 5000) chk("timeout", 64'd1, 64'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (4) @(posedge clk);
        #1;
        chk("rst_out", {60'd0, busy_o, done_o, env_o, txd_o}, 64'd0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_busy", 64'(busy_o), 64'd0);

        send(1'b1, 1'b0, 32'h0000_0000);
        wait_idle();
        send(1'b1, 1'b0, 32'hFFFF_FFFF);
        wait_idle();
        send(1'b1, 1'b0, 32'hE31C_FF00);
        wait_idle();
        send(1'b0, 1'b1, 32'h0000_0000);
        wait_idle();
        send(1'b1, 1'b1, 32'h1234_5678);
        wait_idle();

        // A second request mid-frame must leave the running frame untouched.
        send(1'b1, 1'b0, 32'hA5C3_0F96);
        repeat (300) @(posedge clk);
        #1;
        start_i  = 1'b1;
        repeat_i = 1'b1;
        data_i   = 32'h0000_0000;
        @(posedge clk);
        #1;
        start_i  = 1'b0;
        repeat_i = 1'b0;
        wait_idle();

        for (int k = 0; k < 2; k++) begin
            send(1'b1, 1'b0, $urandom);
            wait_idle();
        end
        chk("frames_left", 64'(frm_q.size()), 64'd0);

        send(1'b1, 1'b0, 32'h0F0F_F0F0);
        repeat (50) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid", {61'd0, busy_o, env_o, txd_o}, 64'd0);
        exp_q.delete();
        frm_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_after", {62'd0, busy_o, done_o}, 64'd0);

        send(1'b0, 1'b1, 32'h0000_0000);
        wait_idle();
        chk("frames_end", 64'(frm_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
